// File: rtl/mem_access_unit.sv
// -----------------------------------------------------------------------------
// mem_access_unit
//   MEM-stage data-memory access controller. Turns a MemRead/MemWrite request
//   from the EX/MEM register into one req/ack transaction on a variable-latency
//   data-memory port. It holds the pipeline stalled until the access finishes
//   or times out.
//
//   Configuration macro: MISALIGN_CHECK_EN
//     defined   -> accesses with Addr_i[1:0] != 0 raise Err_o and go to no memory
//     undefined -> no alignment check; every access is sent to the memory port
//
//   Parameters
//     DATA_W       width of address, write data and read data
//     TIMEOUT_CYC  number of REQ cycles without mem_ack_i before abort (>= 1)
//
//   Ports
//     clk_i        clock, all state changes on posedge
//     rst_i        synchronous active-high reset
//     MemRead_i    load in MEM stage
//     MemWrite_i   store in MEM stage (wins over MemRead_i)
//     Addr_i       byte address, passed to the memory unmodified
//     WrData_i     store data
//     Read_Data_o  load result to MEM/WB; holds its value between loads
//     Stall_o      pipeline freeze (combinational)
//     Err_o        sticky error flag (timeout / misalign), cleared only by reset
//     mem_req_o    memory request valid
//     mem_we_o     1 = write, 0 = read
//     mem_addr_o   memory address
//     mem_wdata_o  memory write data
//     mem_rdata_i  memory read data, valid with mem_ack_i
//     mem_ack_i    memory completion pulse, ignored outside REQ
// -----------------------------------------------------------------------------
module mem_access_unit #(
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              MemRead_i,
    input  logic              MemWrite_i,
    input  logic [DATA_W-1:0] Addr_i,
    input  logic [DATA_W-1:0] WrData_i,
    output logic [DATA_W-1:0] Read_Data_o,
    output logic              Stall_o,
    output logic              Err_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [DATA_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    input  logic              mem_ack_i
);

    localparam int                CNT_W    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ZERO = CNT_W'(0);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_count;
    logic [DATA_W-1:0]  r_read_data;
    logic               r_err;
    logic               r_mem_req;
    logic               r_mem_we;
    logic [DATA_W-1:0]  r_mem_addr;
    logic [DATA_W-1:0]  r_mem_wdata;
    logic               w_access;
    logic               w_misalign;
    logic               w_timeout;
    logic               w_stall;

    assign w_access = MemRead_i | MemWrite_i;

`ifdef MISALIGN_CHECK_EN
    assign w_misalign = (Addr_i[1:0] != 2'b00);
`else
    assign w_misalign = 1'b0;
`endif

    // Last allowed REQ cycle with no ack: the access is aborted at this edge.
    assign w_timeout = (r_count == CNT_LAST);

    // Next-state and stall decode.
    always_comb begin
        w_state_nxt = r_state;
        w_stall     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_access) begin
                    w_stall = 1'b1;
                    if (w_misalign) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_state_nxt = S_REQ;
                    end
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_REQ: begin
                w_stall = 1'b1;
                if (mem_ack_i || w_timeout) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_state_nxt = S_REQ;
                end
            end
            // DONE lasts one cycle. The EX/MEM inputs still show the finished
            // instruction here, so the access must not be issued again.
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Memory-port registers, timeout counter, load result and error flag.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_count     <= CNT_ZERO;
            r_read_data <= {DATA_W{1'b0}};
            r_err       <= 1'b0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= {DATA_W{1'b0}};
            r_mem_wdata <= {DATA_W{1'b0}};
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_access && !w_misalign) begin
                        r_mem_addr  <= Addr_i;
                        r_mem_wdata <= WrData_i;
                        r_mem_we    <= MemWrite_i;
                        r_mem_req   <= 1'b1;
                        r_count     <= CNT_ZERO;
                    end else if (w_access) begin
                        r_err <= 1'b1;
                    end else begin
                        r_mem_req <= 1'b0;
                    end
                end
                S_REQ: begin
                    if (mem_ack_i) begin
                        if (!r_mem_we) begin
                            r_read_data <= mem_rdata_i;
                        end else begin
                            r_read_data <= r_read_data;
                        end
                        r_mem_req <= 1'b0;
                    end else if (w_timeout) begin
                        r_err <= 1'b1;
                        // An aborted load returns zero; an aborted store keeps
                        // the previous load result.
                        if (!r_mem_we) begin
                            r_read_data <= {DATA_W{1'b0}};
                        end else begin
                            r_read_data <= r_read_data;
                        end
                        r_mem_req <= 1'b0;
                    end else begin
                        r_count <= r_count + CNT_ONE;
                    end
                end
                S_DONE: begin
                    r_mem_req <= 1'b0;
                end
                default: begin
                    r_mem_req <= 1'b0;
                end
            endcase
        end
    end

    assign Read_Data_o = r_read_data;
    assign Stall_o     = w_stall;
    assign Err_o       = r_err;
    assign mem_req_o   = r_mem_req;
    assign mem_we_o    = r_mem_we;
    assign mem_addr_o  = r_mem_addr;
    assign mem_wdata_o = r_mem_wdata;

endmodule
